imem_loader: RTL and testbench
==============================

# imem_loader

Boot and reload controller for the core's instruction memory. It accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them into consecutive instruction-RAM addresses starting at 0. While it does this, it holds the core in reset. It then releases the core after a fixed flush interval, so the core's fetch/execute pipeline always restarts cleanly from PC 0. It sits between the external program source and the core's instruction RAM write port and reset input.

## Interface
Parameters:
- ADDR_W, 12, instruction RAM address width (word-addressed)
- DEPTH, 4096, instruction RAM depth in words; must be ≤ 2**ADDR_W
- HOLD_CYCLES, 2, cycles the core stays in reset after the last write; must be ≥ 2 so both pipeline stages clear

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  reset, asynchronous, active-high
- load_start  in  1  single-cycle request to begin a load
- load_len  in  ADDR_W+1  number of words to load, sampled when load_start is accepted
- s_valid  in  1  stream word valid
- s_data  in  32  stream instruction word
- s_ready  out  1  loader can accept a word
- mem_we  out  1  instruction RAM write enable
- mem_addr  out  ADDR_W  instruction RAM write address
- mem_wdata  out  32  instruction RAM write data
- cpu_rst_n  out  1  active-low synchronous reset to the core
- busy  out  1  a load or flush is in progress
- done  out  1  one-cycle pulse when the core is released after a load
- err  out  1  one-cycle pulse when load_start is rejected

## Operation
States: IDLE, LOAD, FLUSH, RUN.

- **IDLE** (entered at reset):
  - cpu_rst_n=0.
  - load_start with load_len in 1..DEPTH: latch the length, clear the word counter, go to LOAD.
  - load_start with load_len=0: go to FLUSH.
  - load_start with load_len>DEPTH: pulse err, stay in IDLE.
- **LOAD**:
  - s_ready=1.
  - Handshake happens when s_valid&&s_ready. mem_we, mem_addr and mem_wdata are combinational: mem_we = s_valid&&s_ready, mem_addr = counter, mem_wdata = s_data.
  - Counter increments on each handshake.
  - On the handshake where counter == len-1, go to FLUSH and load the hold counter with HOLD_CYCLES-1.
  - load_start is ignored in this state.
- **FLUSH**:
  - cpu_rst_n=0, s_ready=0.
  - Hold counter decrements each cycle. At 0, go to RUN and pulse done.
  - load_start is ignored in this state.
- **RUN**:
  - cpu_rst_n=1, busy=0.
  - A valid load_start re-asserts reset: cpu_rst_n=0 from the next cycle and the state goes to LOAD (or FLUSH if load_len=0).
  - A rejected load_start pulses err and leaves the core running.

Other rules:
- busy = 1 in LOAD and FLUSH; 0 otherwise.
- Words presented while s_ready=0 are not consumed, and no write occurs.
- The counter never wraps, because len ≤ DEPTH is guaranteed by the acceptance check.

## Timing
- Reset values: state=IDLE, cpu_rst_n=0, s_ready=0, mem_we=0, mem_addr=0, busy=0, done=0, err=0.
- Asynchronous rst during any state aborts the operation immediately and returns all outputs to their reset values. A partially written RAM is not cleaned up.
- Write latency is 0 cycles: a word is written on the same edge as its handshake.
- Throughput is 1 word/cycle.
- load_start is accepted in cycle N. The state changes at edge N+1, so s_ready first rises in cycle N+1.
- The last handshake occurs in cycle M. The state is FLUSH for cycles M+1 .. M+HOLD_CYCLES. done pulses and cpu_rst_n rises in cycle M+HOLD_CYCLES+1.
- done and err are registered single-cycle pulses. They are never asserted together.

## Structure
- Shared package cpu_pkg holds:
  - loader_state_t (enum of IDLE/LOAD/FLUSH/RUN)
  - IMEM_ADDR_W=12
  - IMEM_DEPTH=4096
- Single module; no sub-module needed.
- Word counter and hold counter are plain registers in the same always_ff as the state register.
- Output decode is in a separate always_comb.

## Test plan
- Reset, then load_start with load_len=3 and three back-to-back words 0x00100093, 0x00200113, 0x002081B3 → writes to addresses 0,1,2 on consecutive cycles; cpu_rst_n=0 throughout, then rises 2 cycles after the last write with a done pulse.
- Same load with s_valid deasserted for 4 cycles between words → no writes while idle, addresses still 0,1,2, same release timing relative to the last write.
- load_len=4097 in IDLE → err pulses for 1 cycle; state, cpu_rst_n and busy unchanged; a later load_len=1 is accepted.
- load_len=0 → no writes; cpu_rst_n rises after HOLD_CYCLES with done.
- In RUN, load_start with load_len=2 → cpu_rst_n falls the next cycle; two words are written to addresses 0 and 1; the core is released again.
- rst asserted mid-LOAD after 1 of 3 words → all outputs return to reset values immediately; after deassertion the state is IDLE and the core is held in reset.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared core-side definitions: instruction-memory geometry and loader FSM states.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    RUN   = 2'd3
  } loader_state_t;

  localparam int IMEM_ADDR_W = 12;
  localparam int IMEM_DEPTH  = 4096;

endpackage

// File: rtl/imem_loader.sv
// Streams words into instruction RAM from address 0 (zero-latency write, 1 word/cycle) with the core held in reset.
// s_ready is high only while loading; the core is released HOLD_CYCLES after the last write.
module imem_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = IMEM_ADDR_W,
  parameter int DEPTH       = IMEM_DEPTH,
  parameter int HOLD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int              HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES - 1);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic len_bad;
  logic len_zero;
  logic last_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      hold_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    hold_d    = hold_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    len_bad   = (load_len > DEPTH_L);
    len_zero  = (load_len == '0);
    last_word = ({1'b0, cnt_q} == (len_q - 1'b1));

    case (state_q)
      IDLE, RUN: begin
        if (load_start) begin
          if (len_bad) begin
            err_d = 1'b1;
          end else if (len_zero) begin
            state_d = FLUSH;
            hold_d  = HOLD_INIT;
          end else begin
            state_d = LOAD;
            len_d   = load_len;
            cnt_d   = '0;
          end
        end
      end
      LOAD: begin
        // The counter is frozen on the final word so len == DEPTH never wraps it.
        if (mem_we) begin
          if (last_word) begin
            state_d = FLUSH;
            hold_d  = HOLD_INIT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (hold_q == '0) begin
          state_d = RUN;
          done_d  = 1'b1;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_ready   = 1'b0;
    cpu_rst_n = 1'b0;
    busy      = 1'b0;
    case (state_q)
      LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b1;
      end
      FLUSH:   busy      = 1'b1;
      RUN:     cpu_rst_n = 1'b1;
      default: ;
    endcase
    mem_we    = s_valid && s_ready;
    mem_addr  = cnt_q;
    mem_wdata = s_data;
    done      = done_q;
    err       = err_q;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expected writes and pulse cycles, monitors pop and compare.
module tb_imem_loader;

  localparam int HOLD = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic [12:0] load_len;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_rst_n;
  logic        busy;
  logic        done;
  logic        err;

  typedef struct {
    logic [11:0] a;
    logic [31:0] d;
    int          c;
  } wr_t;

  wr_t wr_exp[$];
  int  done_exp[$];
  int  err_exp[$];

  int cyc    = 0;
  int n_cmp  = 0;
  int n_bad  = 0;
  int last_m = 0;

  imem_loader #(.ADDR_W(12), .DEPTH(4096), .HOLD_CYCLES(HOLD)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_len   (load_len),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_rst_n  (cpu_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Write monitor
  always @(negedge clk) begin
    wr_t e;
    if (mem_we) begin
      if (wr_exp.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: addr %0h data %08h at cycle %0d, none expected", mem_addr, mem_wdata, cyc);
      end else begin
        e = wr_exp.pop_front();
        chk("wr_addr", {20'd0, mem_addr}, {20'd0, e.a});
        chk("wr_data", mem_wdata, e.d);
        chk("wr_cycle", cyc, e.c);
        chk("wr_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
      end
    end
  end

  // Pulse monitor
  always @(negedge clk) begin
    if (done && err) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_err_overlap: both high at cycle %0d, required exclusive", cyc);
    end
    if (done) begin
      if (done_exp.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: pulse at cycle %0d, none expected", cyc);
      end else begin
        chk("done_cycle", cyc, done_exp.pop_front());
      end
    end
    if (err) begin
      if (err_exp.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_err: pulse at cycle %0d, none expected", cyc);
      end else begin
        chk("err_cycle", cyc, err_exp.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [12:0] len);
    load_start = 1'b1;
    load_len   = len;
    tick();
    load_start = 1'b0;
    load_len   = '0;
  endtask

  task automatic send(input logic [31:0] d, input logic [11:0] a);
    wr_t e;
    s_valid = 1'b1;
    s_data  = d;
    e.a = a;
    e.d = d;
    e.c = cyc;
    wr_exp.push_back(e);
    last_m = cyc;
    tick();
    s_valid = 1'b0;
  endtask

  // m: cycle of the last handshake (or of acceptance for a zero-length load)
  task automatic release_chk(input int m);
    done_exp.push_back(m + HOLD + 1);
    while (cyc < m + HOLD) tick();
    chk("flush_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    chk("flush_busy", {31'd0, busy}, 32'd1);
    chk("flush_s_ready", {31'd0, s_ready}, 32'd0);
    tick();
    chk("run_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
    chk("run_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int m;
    rst        = 1'b1;
    load_start = 1'b0;
    load_len   = '0;
    s_valid    = 1'b1;
    s_data     = 32'hDEADBEEF;
    #3;
    chk("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    s_valid = 1'b0;

    // Back-to-back three-word load
    start(13'd3);
    chk("load_s_ready", {31'd0, s_ready}, 32'd1);
    chk("load_busy", {31'd0, busy}, 32'd1);
    chk("load_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    send(32'h00100093, 12'd0);
    send(32'h00200113, 12'd1);
    send(32'h002081B3, 12'd2);
    release_chk(last_m);
    tick();

    // Same load with stalls, issued from RUN
    start(13'd3);
    chk("reload_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    send(32'h00100093, 12'd0);
    repeat (4) tick();
    send(32'h00200113, 12'd1);
    repeat (4) tick();
    send(32'h002081B3, 12'd2);
    release_chk(last_m);
    tick();

    // Oversize request in IDLE, then a one-word load
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    err_exp.push_back(cyc + 1);
    start(13'd4097);
    chk("err_idle_busy", {31'd0, busy}, 32'd0);
    chk("err_idle_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    chk("err_idle_s_ready", {31'd0, s_ready}, 32'd0);
    tick();
    start(13'd1);
    chk("len1_s_ready", {31'd0, s_ready}, 32'd1);
    send(32'hA5A50001, 12'd0);
    release_chk(last_m);
    tick();

    // Oversize request in RUN leaves the core running
    err_exp.push_back(cyc + 1);
    start(13'h1FFF);
    chk("err_run_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
    chk("err_run_busy", {31'd0, busy}, 32'd0);
    tick();

    // Zero-length load: flush only
    m = cyc;
    start(13'd0);
    chk("len0_s_ready", {31'd0, s_ready}, 32'd0);
    chk("len0_busy", {31'd0, busy}, 32'd1);
    release_chk(m);
    tick();

    // Reload of two words from RUN
    start(13'd2);
    chk("run_reload_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    send(32'h11111111, 12'd0);
    send(32'h22222222, 12'd1);
    release_chk(last_m);
    tick();

    // Full-depth length is accepted; abort it after one word
    start(13'd4096);
    chk("depth_s_ready", {31'd0, s_ready}, 32'd1);
    chk("depth_busy", {31'd0, busy}, 32'd1);
    send(32'h0BAD0000, 12'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Asynchronous reset mid-load after one of three words
    start(13'd3);
    send(32'hCAFE0000, 12'd0);
    chk("mid_addr", {20'd0, mem_addr}, 32'd1);
    s_valid = 1'b1;
    s_data  = 32'hCAFE0001;
    #2;
    rst = 1'b1;
    #1;
    chk("abort_s_ready", {31'd0, s_ready}, 32'd0);
    chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
    chk("abort_mem_addr", {20'd0, mem_addr}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_err", {31'd0, err}, 32'd0);
    s_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("post_abort_busy", {31'd0, busy}, 32'd0);
    chk("post_abort_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    chk("post_abort_s_ready", {31'd0, s_ready}, 32'd0);
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    start(13'd1);
    send(32'h12345678, 12'd0);
    release_chk(last_m);

    repeat (4) tick();
    chk("pending_writes", wr_exp.size(), 32'd0);
    chk("pending_done", done_exp.size(), 32'd0);
    chk("pending_err", err_exp.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
